// File: rtl/fold_reduce_pkg.sv
// Shared types and defaults for the fold-based modular reducer (fold_reduce_pipe).
// Fermat-form support is built only when FOLD_REDUCE_FERMAT_EN is defined.
package fold_reduce_pkg;

    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_NUM_FOLDS = 4;
    localparam int unsigned DEF_TAG_W     = 4;

    // Payload fields are sized for the widest build; narrower builds zero-extend into them.
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned MAX_TAG_W  = 8;
    localparam int unsigned ACC_W      = MAX_DATA_W + 2;
    localparam int unsigned K_W        = $clog2(MAX_DATA_W + 1);

    localparam logic [MAX_DATA_W-1:0] ONE_D = {{(MAX_DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MOD_MERSENNE,
        MOD_FERMAT,
        MOD_UNSUPPORTED
    } mod_class_t;

    typedef struct packed {
        logic signed [ACC_W-1:0]  acc;
        logic [MAX_DATA_W-1:0]    x;     // operand bits not yet folded
        logic [MAX_DATA_W-1:0]    m;
        logic [K_W-1:0]           k;
        mod_class_t               cls;
        logic                     sign;  // 1: this stage subtracts its chunk
        logic                     err;
        logic [MAX_TAG_W-1:0]     tag;
    } fold_payload_t;

    function automatic logic [MAX_DATA_W-1:0] low_mask(input logic [K_W-1:0] n);
        return (ONE_D << n) - ONE_D;
    endfunction

endpackage

// File: rtl/fold_stage.sv
// One fold step: add (or subtract) the next k-bit chunk, correct once into [0, m), register.
// Subtraction and negative correction exist only with FOLD_REDUCE_FERMAT_EN.
module fold_stage
    import fold_reduce_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_en,
    input  logic          i_valid,
    input  fold_payload_t i_pld,
    output logic          o_valid,
    output fold_payload_t o_pld
);

    logic signed [ACC_W-1:0] w_chunk;
    logic signed [ACC_W-1:0] w_m;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_acc;
    fold_payload_t           w_next;
    logic                    r_valid;
    fold_payload_t           r_pld;

    always_comb begin
        w_chunk = {2'b00, i_pld.x & low_mask(i_pld.k)};
        w_m     = {2'b00, i_pld.m};
        w_sum   = i_pld.acc + w_chunk;
`ifdef FOLD_REDUCE_FERMAT_EN
        if (i_pld.sign) begin
            w_sum = i_pld.acc - w_chunk;
        end
`endif
        w_acc = w_sum;
        if (w_sum >= w_m) begin
            w_acc = w_sum - w_m;
        end
`ifdef FOLD_REDUCE_FERMAT_EN
        else if (w_sum[ACC_W-1]) begin
            w_acc = w_sum + w_m;
        end
`endif
        w_next      = i_pld;
        w_next.acc  = w_acc;
        w_next.x    = i_pld.x >> i_pld.k;
        w_next.sign = (i_pld.cls == MOD_FERMAT) ? ~i_pld.sign : 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_pld   <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_pld   <= w_next;
        end
    end

    assign o_valid = r_valid;
    assign o_pld   = r_pld;

endmodule

// File: rtl/fold_reduce_pipe.sv
// Pipelined x mod m for Mersenne (and, with FOLD_REDUCE_FERMAT_EN, Fermat-form) moduli.
// NUM_FOLDS fold stages, latency NUM_FOLDS, whole pipeline freezes on output backpressure.
module fold_reduce_pipe
    import fold_reduce_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_FOLDS = DEF_NUM_FOLDS,
    parameter int unsigned TAG_W     = DEF_TAG_W
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [DATA_W-1:0]           x_i,
    input  logic [DATA_W-1:0]           m_i,
    input  logic [$clog2(DATA_W+1)-1:0] m_bl_i,
    input  logic [TAG_W-1:0]            tag_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [DATA_W-1:0]           result_o,
    output logic [TAG_W-1:0]            tag_o,
    output logic                        err_o
);

    localparam logic [K_W-1:0] BL_MIN = K_W'(2);
    localparam logic [K_W-1:0] BL_MAX = K_W'(DATA_W);
    localparam logic [K_W-1:0] BL_ONE = K_W'(1);

    logic [MAX_DATA_W-1:0] w_m;
    logic [K_W-1:0]        w_bl;
    logic [K_W-1:0]        w_k;
    mod_class_t            w_cls;
    fold_payload_t         w_in;
    fold_payload_t         w_pld [NUM_FOLDS];
    logic                  w_vld [NUM_FOLDS];
    fold_payload_t         w_out;
    logic                  w_en;
    logic                  w_err;
    logic                  w_unused_out;

    assign w_m  = MAX_DATA_W'(m_i);
    assign w_bl = K_W'(m_bl_i);

    always_comb begin
        w_cls = MOD_UNSUPPORTED;
        w_k   = '0;
        if (w_bl >= BL_MIN && w_bl <= BL_MAX) begin
            if (w_m == low_mask(w_bl)) begin
                w_cls = MOD_MERSENNE;
                w_k   = w_bl;
            end
`ifdef FOLD_REDUCE_FERMAT_EN
            else if (w_m == ((ONE_D << (w_bl - BL_ONE)) | ONE_D)) begin
                w_cls = MOD_FERMAT;
                w_k   = w_bl - BL_ONE;
            end
`endif
        end
    end

    always_comb begin
        w_in      = '0;
        w_in.x    = MAX_DATA_W'(x_i);
        w_in.m    = w_m;
        w_in.k    = w_k;
        w_in.cls  = w_cls;
        w_in.sign = 1'b0;
        w_in.err  = (w_cls == MOD_UNSUPPORTED);
        w_in.tag  = MAX_TAG_W'(tag_i);
    end

    assign ready_o = !(valid_o && !ready_i);
    assign w_en    = ready_o;

    for (genvar g = 0; g < NUM_FOLDS; g++) begin : g_fold
        fold_payload_t w_stage_in;
        logic          w_stage_vld;
        if (g == 0) begin : g_first
            assign w_stage_in  = w_in;
            assign w_stage_vld = valid_i;
        end else begin : g_rest
            assign w_stage_in  = w_pld[g-1];
            assign w_stage_vld = w_vld[g-1];
        end
        fold_stage u_fold_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .i_en    (w_en),
            .i_valid (w_stage_vld),
            .i_pld   (w_stage_in),
            .o_valid (w_vld[g]),
            .o_pld   (w_pld[g])
        );
    end

    assign w_out   = w_pld[NUM_FOLDS-1];
    assign valid_o = w_vld[NUM_FOLDS-1];

    // Bits at or above NUM_FOLDS*k are never folded away, so any left over means x_i was out of range.
    assign w_err    = w_out.err || (w_out.x != '0);
    assign result_o = w_err ? '0 : w_out.acc[DATA_W-1:0];
    assign tag_o    = w_out.tag[TAG_W-1:0];
    assign err_o    = w_err;

    assign w_unused_out = ^w_out;

endmodule

// File: doc/fold_reduce_pipe.md
FOLD_REDUCE_PIPE -- requirements
Module: fold_reduce_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of x_i, m_i and result_o.
REQ-002 SHALL have parameter NUM_FOLDS, default 4: number of fold stages, which is also the latency in cycles.
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag.
REQ-004 SHALL have port clk_i, input, 1 bit: clock, rising-edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports valid_i (input, 1) and ready_o (output, 1): input handshake.
REQ-007 SHALL have ports x_i (input, DATA_W) for the operand, m_i (input, DATA_W) for the modulus, and m_bl_i (input, $clog2(DATA_W+1)) for the modulus bit length.
REQ-008 SHALL have port tag_i (input, TAG_W): tag carried unchanged alongside its operand.
REQ-009 SHALL have ports valid_o (output, 1) and ready_i (input, 1): output handshake.
REQ-010 SHALL have ports result_o (output, DATA_W), tag_o (output, TAG_W) and err_o (output, 1).

Function
REQ-011 SHALL classify m_i at acceptance, and carry the class with the operand through every stage:
- Mersenne when m_i == 2^m_bl_i-1, giving k = m_bl_i.
- Fermat when m_i == 2^(m_bl_i-1)+1, giving k = m_bl_i-1.
- Otherwise unsupported.
REQ-012 SHALL treat m_bl_i < 2 as unsupported.
REQ-013 SHALL split x_i into k-bit chunks c0..c(NUM_FOLDS-1), with c0 being the least significant.
REQ-014 SHALL have stage j (j = 0..NUM_FOLDS-1) compute acc_j = acc_(j-1) + s_j*c_j, with acc_(-1) = 0, then apply exactly one correction so that acc_j lies in [0, m).
- Mersenne: s_j = +1; subtract m if acc_j >= m.
- Fermat: s_j = (-1)^j; add m if acc_j < 0, or subtract m if acc_j >= m.
REQ-015 SHALL use signed accumulators of width DATA_W+2, so no intermediate overflows.
REQ-016 SHALL set err_o = 1 and result_o = 0 when the operand is unsupported, or when x_i has any nonzero bit at position >= NUM_FOLDS*k.
REQ-017 SHALL produce result_o = x_i mod m_i, with err_o = 0, for every supported input.
REQ-018 SHALL have a latency of exactly NUM_FOLDS cycles from the accept edge (valid_i && ready_o) to valid_o, when there is no stall.
REQ-019 SHALL sustain a throughput of one operand per cycle.
REQ-020 SHALL assign ready_o = !(valid_o && !ready_i), and SHALL freeze the whole pipeline (data, tag and valid of every stage) while ready_o = 0.
REQ-021 SHALL keep result_o, tag_o and err_o stable while valid_o = 1 and ready_i = 0.
REQ-022 SHALL keep results in input order and SHALL never drop or duplicate a result.
REQ-023 SHALL allow stage valid bits to be non-contiguous: bubbles propagate and collapse only at a stall.
REQ-024 SHALL make a completed result visible on valid_o and accept a new operand in the same cycle when ready_i = 1.

Reset
REQ-025 SHALL clear every stage valid bit, valid_o, result_o, tag_o and err_o to 0 while rst_ni = 0.
REQ-026 SHALL discard all in-flight operands when reset is asserted mid-operation, and SHALL emit none of them after release.
REQ-027 SHALL drive ready_o = 1 from the first cycle after reset release.

Configuration
REQ-028 SHALL support the macro FOLD_REDUCE_FERMAT_EN.
- Defined: Fermat classification and alternating-sign folding are built.
- Undefined: only Mersenne moduli are supported; Fermat-form moduli report err_o = 1; no negative-correction logic is synthesised.

Structure
REQ-029 SHALL place the following in package fold_reduce_pkg: enum mod_class_t {MOD_MERSENNE, MOD_FERMAT, MOD_UNSUPPORTED}, the stage payload struct (acc, m, k, class, sign, err, tag), and the default parameter constants.
REQ-030 SHALL implement each fold step as sub-module fold_stage, instantiated NUM_FOLDS times via generate.

Verification (defaults; FOLD_REDUCE_FERMAT_EN defined)
REQ-031 SHALL cover: m = 2^31-1, m_bl = 31, x = 2^64-1 -> result 3, err 0, valid_o exactly 4 cycles after accept.
REQ-032 SHALL cover: m = 2^16+1, m_bl = 17, x = 2^48 -> result 65536; x = 65537 -> result 0.
REQ-033 SHALL cover: m = 255, m_bl = 8, x = 2^40 -> err 1, result 0; m = 1000 -> err 1.
REQ-034 SHALL cover: stream 8 operands with tags 0..7 while ready_i is held 0 for 3 cycles mid-stream -> 8 results with tags in order 0..7, all correct, outputs stable during the stall.
REQ-035 SHALL cover: assert rst_ni = 0 with 3 operands in flight -> valid_o and all outputs 0, no stale result after release, and ready_o = 1 in the first cycle after release.
REQ-036 SHALL cover: a build without FOLD_REDUCE_FERMAT_EN, m = 2^16+1 -> err 1; the Mersenne case of REQ-031 is unchanged.
